// File: rtl/present_redundant_ctrl_if.sv
// Host-side request/response bundle of present_redundant_ctrl: start/ready handshake,
// plaintext and key in, ciphertext and its valid strobe out.
interface present_redundant_ctrl_if;
    logic        start_i;
    logic        ready_o;
    logic [63:0] data_i;
    logic [79:0] key_i;
    logic [63:0] data_o;
    logic        data_o_valid;

    modport master (
        output start_i, data_i, key_i,
        input  ready_o, data_o, data_o_valid
    );

    modport slave (
        input  start_i, data_i, key_i,
        output ready_o, data_o, data_o_valid
    );
endinterface

// File: rtl/present_redundant_ctrl.sv
// PRESENT-80 fault countermeasure: NCOPY lockstep round-iterative cores, a controller FSM
// that compares (MODE 0) or majority-votes (MODE 1) their results, and a fault/alarm counter.

module present_encryptor_top (
    input  logic        clk_i,
    input  logic        rst,
    input  logic [63:0] data_i,
    input  logic [79:0] key_i,
    input  logic        data_load_i,
    input  logic        key_load_i,
    input  logic        cointoss_i,
    output logic [63:0] data_o,
    output logic        data_o_valid
);
    logic [63:0] state_q, state_d;
    logic [79:0] key_q, key_d;
    logic [4:0]  round_q, round_d;
    logic        busy_q, busy_d;
    logic        valid_q, valid_d;
    logic [63:0] dout_q, dout_d;
    logic [63:0] round_state;
    logic [79:0] key_rot, next_key;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
            4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
            4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
            4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [63:0] s_layer(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int n = 0; n < 16; n++) y[4*n +: 4] = sbox(x[4*n +: 4]);
        return y;
    endfunction

    // Bit i moves to 16*(i mod 4) + i/4, i.e. the two index fields swap places.
    function automatic logic [63:0] p_layer(input logic [63:0] x);
        logic [63:0] y;
        logic [5:0]  src;
        y = '0;
        for (int i = 0; i < 64; i++) begin
            src = 6'(i);
            y[{src[1:0], src[5:2]}] = x[src];
        end
        return y;
    endfunction

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        key_rot     = {key_q[18:0], key_q[79:19]};
        next_key    = {sbox(key_rot[79:76]), key_rot[75:20], key_rot[19:15] ^ round_q,
                       key_rot[14:0]};
        round_state = p_layer(s_layer(state_q ^ key_q[79:16]));
        state_d     = state_q;
        key_d       = key_q;
        round_d     = round_q;
        busy_d      = busy_q;
        valid_d     = valid_q;
        dout_d      = dout_q;
        if (data_load_i || key_load_i) begin
            if (data_load_i) state_d = data_i;
            if (key_load_i)  key_d   = key_i;
            round_d = 5'd1;
            busy_d  = 1'b1;
            valid_d = 1'b0;
        end else if (busy_q && !cointoss_i) begin
            // cointoss inserts a dummy cycle; all cores see the same bit and stay in lockstep
            state_d = round_state;
            key_d   = next_key;
            round_d = round_q + 5'd1;
            if (round_q == 5'd31) begin
                busy_d  = 1'b0;
                valid_d = 1'b1;
                dout_d  = round_state ^ next_key[79:16];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            state_q <= '0;
            key_q   <= '0;
            round_q <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            dout_q  <= dout_d;
        end
    end

    assign data_o       = dout_q;
    assign data_o_valid = valid_q;
endmodule

module present_redundant_ctrl #(
    parameter int NCOPY     = 2,
    parameter int MODE      = 0,
    parameter int TIMEOUT   = 64,
    parameter int ALARM_THR = 3,
    parameter int CNT_W     = 8
) (
    input  logic                     clk_i,
    input  logic                     rst,
    present_redundant_ctrl_if.slave  bus,
    input  logic                     cointoss,
    input  logic                     clr_alarm_i,
    output logic                     fault_o,
    output logic                     alarm_o,
    output logic [CNT_W-1:0]         fault_cnt_o
);
    localparam int T_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RUN, S_CHECK, S_OUT, S_LOCK
    } state_t;

    state_t                state_q, state_d;
    logic [63:0]           pt_q, pt_d;
    logic [79:0]           key_q, key_d;
    logic [T_W-1:0]        timer_q, timer_d;
    logic                  tmo_q, tmo_d;
    logic [63:0]           result_q, result_d;
    logic                  fault_q, fault_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
    logic                  load_w;

    logic [NCOPY-1:0][63:0] core_data;
    logic [NCOPY-1:0]       core_valid;

    for (genvar g = 0; g < NCOPY; g++) begin : g_core
        logic [63:0] core_dout;
        logic        core_vld;

        present_encryptor_top u_core (
            .clk_i        (clk_i),
            .rst          (rst),
            .data_i       (pt_q),
            .key_i        (key_q),
            .data_load_i  (load_w),
            .key_load_i   (load_w),
            .cointoss_i   (cointoss),
            .data_o       (core_dout),
            .data_o_valid (core_vld)
        );

        assign core_data[g]  = core_dout;
        assign core_valid[g] = core_vld;
    end

    logic [63:0] maj;
    logic        all_eq, any_diff;
    logic [63:0] vote_data;
    logic        vote_fault;
    int          ones;

    always_comb begin
        all_eq   = 1'b1;
        any_diff = 1'b0;
        maj      = '0;
        ones     = 0;
        for (int c = 1; c < NCOPY; c++)
            if (core_data[c] != core_data[0]) all_eq = 1'b0;
        for (int b = 0; b < 64; b++) begin
            ones = 0;
            for (int c = 0; c < NCOPY; c++) ones = ones + int'(core_data[c][b]);
            maj[b] = (ones > NCOPY / 2);
        end
        for (int c = 0; c < NCOPY; c++)
            if (core_data[c] != maj) any_diff = 1'b1;

        vote_data  = '0;
        vote_fault = 1'b1;
        if (!tmo_q) begin
            if (MODE == 1) begin
                vote_data  = maj;
                vote_fault = any_diff;
            end else if (all_eq) begin
                vote_data  = core_data[0];
                vote_fault = 1'b0;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        pt_d     = pt_q;
        key_d    = key_q;
        timer_d  = timer_q;
        tmo_d    = tmo_q;
        result_d = result_q;
        fault_d  = fault_q;
        cnt_d    = cnt_q;
        load_w   = 1'b0;
        cnt_inc  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    pt_d    = bus.data_i;
                    key_d   = bus.key_i;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                load_w  = 1'b1;
                timer_d = '0;
                tmo_d   = 1'b0;
                state_d = S_RUN;
            end
            S_RUN: begin
                timer_d = timer_q + 1'b1;
                if (&core_valid) begin
                    state_d = S_CHECK;
                end else if (timer_d == T_W'(TIMEOUT)) begin
                    tmo_d   = 1'b1;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                result_d = vote_data;
                fault_d  = vote_fault;
                state_d  = S_OUT;
            end
            S_OUT: begin
                if (fault_q) cnt_d = cnt_inc;
                state_d = (cnt_d >= CNT_W'(ALARM_THR)) ? S_LOCK : S_IDLE;
            end
            S_LOCK: begin
                if (clr_alarm_i) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            pt_q     <= '0;
            key_q    <= '0;
            timer_q  <= '0;
            tmo_q    <= 1'b0;
            result_q <= '0;
            fault_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pt_q     <= pt_d;
            key_q    <= key_d;
            timer_q  <= timer_d;
            tmo_q    <= tmo_d;
            result_q <= result_d;
            fault_q  <= fault_d;
            cnt_q    <= cnt_d;
        end
    end

    // result_q only changes on the CHECK->OUT edge, so it holds the last answer until the next OUT
    assign bus.data_o       = (state_q == S_LOCK) ? '0 : result_q;
    assign bus.data_o_valid = (state_q == S_OUT);
    assign bus.ready_o      = (state_q == S_IDLE);
    assign fault_o          = (state_q == S_OUT) && fault_q;
    assign alarm_o          = (state_q == S_LOCK);
    assign fault_cnt_o      = cnt_q;
endmodule

// File: tb/tb_present_redundant_ctrl.sv
// Directed bench: a 2-core suppressing instance and a 3-core voting instance, with a queue
// of expected results checked whenever a valid pulse appears.
module tb_present_redundant_ctrl;
    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic       rst;
    logic       cointoss;
    logic       clr_s, clr_v;
    logic       fault_s, fault_v, alarm_s, alarm_v;
    logic [7:0] cnt_s, cnt_v;

    present_redundant_ctrl_if bus_s ();
    present_redundant_ctrl_if bus_v ();

    present_redundant_ctrl #(.NCOPY(2), .MODE(0), .TIMEOUT(64), .ALARM_THR(3), .CNT_W(8)) dut_s (
        .clk_i(clk_i), .rst(rst), .bus(bus_s), .cointoss(cointoss), .clr_alarm_i(clr_s),
        .fault_o(fault_s), .alarm_o(alarm_s), .fault_cnt_o(cnt_s)
    );

    present_redundant_ctrl #(.NCOPY(3), .MODE(1), .TIMEOUT(64), .ALARM_THR(3), .CNT_W(8)) dut_v (
        .clk_i(clk_i), .rst(rst), .bus(bus_v), .cointoss(cointoss), .clr_alarm_i(clr_v),
        .fault_o(fault_v), .alarm_o(alarm_v), .fault_cnt_o(cnt_v)
    );

    typedef struct {
        logic [63:0] data;
        logic        fault;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    localparam logic [63:0] ONES64 = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [79:0] ONES80 = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic dut_valid(input int sel);
        return (sel == 0) ? bus_s.data_o_valid : bus_v.data_o_valid;
    endfunction
    function automatic logic [63:0] dut_data(input int sel);
        return (sel == 0) ? bus_s.data_o : bus_v.data_o;
    endfunction
    function automatic logic dut_fault(input int sel);
        return (sel == 0) ? fault_s : fault_v;
    endfunction
    function automatic logic dut_ready(input int sel);
        return (sel == 0) ? bus_s.ready_o : bus_v.ready_o;
    endfunction

    task automatic issue(input int sel, input logic [63:0] d, input logic [79:0] k,
                         input logic [63:0] exp_d, input logic exp_f);
        sb_q.push_back('{data: exp_d, fault: exp_f});
        if (sel == 0) begin
            bus_s.data_i = d; bus_s.key_i = k; bus_s.start_i = 1'b1;
        end else begin
            bus_v.data_i = d; bus_v.key_i = k; bus_v.start_i = 1'b1;
        end
        @(negedge clk_i);
        bus_s.start_i = 1'b0;
        bus_v.start_i = 1'b0;
    endtask

    // exp_lat counts rising edges from the accepting edge up to the one that raises valid
    task automatic collect(input int sel, input string tag, input int exp_lat);
        int   lat;
        exp_t e;
        lat = 1;
        while (!dut_valid(sel) && lat < 200) begin
            @(negedge clk_i);
            lat++;
        end
        check({tag, " valid_seen"}, 64'(dut_valid(sel)), 64'd1);
        if (sb_q.size() == 0) begin
            check({tag, " scoreboard_nonempty"}, 64'd0, 64'd1);
        end else begin
            e = sb_q.pop_front();
            check({tag, " data"}, dut_data(sel), e.data);
            check({tag, " fault"}, 64'(dut_fault(sel)), 64'(e.fault));
        end
        if (exp_lat > 0) check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        @(negedge clk_i);
        check({tag, " valid_one_cycle"}, 64'(dut_valid(sel)), 64'd0);
        check({tag, " fault_one_cycle"}, 64'(dut_fault(sel)), 64'd0);
    endtask

    task automatic quiet(input int sel, input int n, input string tag);
        int pulses;
        pulses = 0;
        repeat (n) begin
            @(negedge clk_i);
            if (dut_valid(sel)) pulses++;
        end
        check(tag, 64'(pulses), 64'd0);
    endtask

    initial begin
        rst = 1'b0; cointoss = 1'b0; clr_s = 1'b0; clr_v = 1'b0;
        bus_s.start_i = 1'b0; bus_s.data_i = '0; bus_s.key_i = '0;
        bus_v.start_i = 1'b0; bus_v.data_i = '0; bus_v.key_i = '0;
        repeat (3) @(negedge clk_i);
        check("reset data_o", bus_s.data_o, 64'd0);
        check("reset valid", 64'(bus_s.data_o_valid), 64'd0);
        check("reset fault", 64'(fault_s), 64'd0);
        check("reset alarm", 64'(alarm_s), 64'd0);
        check("reset count", 64'(cnt_s), 64'd0);
        rst = 1'b1;
        @(negedge clk_i);
        check("ready after reset s", 64'(bus_s.ready_o), 64'd1);
        check("ready after reset v", 64'(bus_v.ready_o), 64'd1);

        // Clean encryption through the suppressing pair
        issue(0, 64'd0, 80'd0, 64'h5579C1387B228445, 1'b0);
        collect(0, "t1", -1);
        check("t1 ready_back", 64'(bus_s.ready_o), 64'd1);
        check("t1 data_held", bus_s.data_o, 64'h5579C1387B228445);
        check("t1 count", 64'(cnt_s), 64'd0);

        // Repeated mismatches: suppression, counting, lock, start ignored, clear
        force dut_s.g_core[0].core_dout = 64'h2112FFC72F68417B;
        for (int r = 1; r <= 3; r++) begin
            issue(0, ONES64, 80'd0, 64'd0, 1'b1);
            collect(0, $sformatf("t3 run%0d", r), -1);
            check($sformatf("t3 count%0d", r), 64'(cnt_s), 64'(r));
        end
        check("t3 alarm", 64'(alarm_s), 64'd1);
        check("t3 ready_locked", 64'(bus_s.ready_o), 64'd0);
        check("t3 data_locked", bus_s.data_o, 64'd0);
        bus_s.data_i = 64'd0; bus_s.key_i = 80'd0; bus_s.start_i = 1'b1;
        @(negedge clk_i);
        bus_s.start_i = 1'b0;
        quiet(0, 40, "t3 start_ignored_in_lock");
        check("t3 alarm_held", 64'(alarm_s), 64'd1);
        check("t3 count_held", 64'(cnt_s), 64'd3);
        clr_s = 1'b1;
        @(negedge clk_i);
        clr_s = 1'b0;
        check("t3 alarm_cleared", 64'(alarm_s), 64'd0);
        check("t3 count_cleared", 64'(cnt_s), 64'd0);
        check("t3 ready_after_clear", 64'(bus_s.ready_o), 64'd1);
        release dut_s.g_core[0].core_dout;

        // Voting triple outvotes a single corrupted core but still flags the fault
        force dut_v.g_core[1].core_dout = 64'hE72C46C0F5945048;
        issue(1, 64'd0, ONES80, 64'hE72C46C0F5945049, 1'b1);
        collect(1, "t2", -1);
        check("t2 count", 64'(cnt_v), 64'd1);
        release dut_v.g_core[1].core_dout;

        // A core that never finishes: exactly 64 RUN cycles, then a suppressed faulty result
        force dut_v.g_core[2].core_vld = 1'b0;
        issue(1, ONES64, ONES80, 64'd0, 1'b1);
        collect(1, "t4", 67);
        check("t4 count", 64'(cnt_v), 64'd2);
        check("t4 ready", 64'(bus_v.ready_o), 64'd1);
        release dut_v.g_core[2].core_vld;

        // Clear request in IDLE has no effect
        clr_v = 1'b1;
        @(negedge clk_i);
        clr_v = 1'b0;
        @(negedge clk_i);
        check("t6 clr_idle count", 64'(cnt_v), 64'd2);
        check("t6 clr_idle ready", 64'(bus_v.ready_o), 64'd1);
        check("t6 clr_idle alarm", 64'(alarm_v), 64'd0);

        // Start during RUN is dropped, not queued
        issue(0, ONES64, ONES80, 64'h3333DCD3213210D2, 1'b0);
        repeat (5) @(negedge clk_i);
        bus_s.data_i = 64'd0; bus_s.key_i = 80'd0; bus_s.start_i = 1'b1;
        @(negedge clk_i);
        bus_s.start_i = 1'b0;
        check("t6 busy_not_ready", 64'(bus_s.ready_o), 64'd0);
        collect(0, "t6", -1);
        quiet(0, 50, "t6 no_second_run");
        check("t6 data_held", bus_s.data_o, 64'h3333DCD3213210D2);

        // Reset in the middle of a run clears everything at once
        bus_s.data_i = ONES64; bus_s.key_i = ONES80; bus_s.start_i = 1'b1;
        @(negedge clk_i);
        bus_s.start_i = 1'b0;
        repeat (10) @(negedge clk_i);
        rst = 1'b0;
        #1;
        check("t5 data_o", bus_s.data_o, 64'd0);
        check("t5 valid", 64'(bus_s.data_o_valid), 64'd0);
        check("t5 fault", 64'(fault_s), 64'd0);
        check("t5 alarm", 64'(alarm_s), 64'd0);
        check("t5 count_v", 64'(cnt_v), 64'd0);
        @(negedge clk_i);
        rst = 1'b1;
        quiet(0, 60, "t5 no_pulse_after_abort");
        check("t5 ready", 64'(bus_s.ready_o), 64'd1);
        issue(0, 64'd0, 80'd0, 64'h5579C1387B228445, 1'b0);
        collect(0, "t5 rerun", -1);

        check("scoreboard drained", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
